// File: rtl/dac_link_pkg.sv
// Shared definitions for the dual-lane sync-framed serial DAC link.
// Imported by both the link transmitter and the receiver (dac_frame_rx).
package dac_link_pkg;

   // Bits per frame per lane.
   localparam int DAC_WORD_W = 16;

   // Level of sync that marks "frame in progress"; the idle level is its inverse.
   localparam logic SYNC_ACTIVE = 1'b0;

   // Receiver frame-tracking states.
   typedef enum logic [1:0] {
      WAIT_IDLE = 2'd0,  // ignore the line until sync is seen idle
      IDLE      = 2'd1,  // armed, waiting for the first active sync sample
      SHIFT     = 2'd2,  // collecting data bits
      DRAIN     = 2'd3   // word complete, expecting sync to return idle
   } rx_state_t;

endpackage

// File: rtl/dac_rx_lane.sv
// One receive lane: WIDTH-bit MSB-first shift register plus an output word
// register that is loaded with the completed word on the last data bit.
module dac_rx_lane
   import dac_link_pkg::*;
#(
   parameter int WIDTH = DAC_WORD_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   input  logic             start,
   input  logic             shift,
   input  logic             load,
   output logic [WIDTH-1:0] word
);

   logic [WIDTH-1:0] shreg;

   // Shift register and completed-word register.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours, independent of block order.
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg <= '0;
         word  <= '0;
      end else begin
         if (start) begin
            shreg <= {{(WIDTH-1){1'b0}}, din};
         end else if (shift) begin
            shreg <= {shreg[WIDTH-2:0], din};
         end
         // The last bit is still on din, so the completed word is formed
         // directly rather than waiting for it to land in shreg.
         if (load) begin
            word <= {shreg[WIDTH-2:0], din};
         end
      end
   end

endmodule

// File: rtl/dac_frame_rx.sv
// Receiver/deserialiser for the dual-lane sync-framed serial DAC link.
// Recovers each A/B word pair, strobes valid, and flags short or over-length
// frames with frame_err.
// Optional build macro DAC_FRAME_RX_IN_REG_EN: adds one input register stage on
// sync/dina/dinb, delaying valid and frame_err by one cycle.
module dac_frame_rx
   import dac_link_pkg::*;
#(
   parameter int WIDTH = DAC_WORD_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sync,
   input  logic             dina,
   input  logic             dinb,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b,
   output logic             valid,
   output logic             frame_err,
   output logic             busy
);

   localparam int              CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   logic             sync_s;
   logic             dina_s;
   logic             dinb_s;
   rx_state_t        state;
   logic [CNT_W-1:0] count;
   logic             frame_low;
   logic             lane_start;
   logic             lane_shift;
   logic             lane_load;

`ifdef DAC_FRAME_RX_IN_REG_EN
   // Extra input stage; resets to an idle line so no false frame start follows reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_s <= ~SYNC_ACTIVE;
         dina_s <= 1'b0;
         dinb_s <= 1'b0;
      end else begin
         sync_s <= sync;
         dina_s <= dina;
         dinb_s <= dinb;
      end
   end
`else
   assign sync_s = sync;
   assign dina_s = dina;
   assign dinb_s = dinb;
`endif

   // Lane control strobes decoded from the current state and this cycle's sample.
   // NOTE: every signal assigned here gets a value on every path (defaults
   // first), so no latch is inferred.
   always_comb begin
      frame_low  = 1'b0;
      lane_start = 1'b0;
      lane_shift = 1'b0;
      lane_load  = 1'b0;
      frame_low  = (sync_s == SYNC_ACTIVE);
      lane_start = (state == IDLE)  && frame_low;
      lane_shift = (state == SHIFT) && frame_low;
      lane_load  = lane_shift && (count == LAST_CNT);
   end

   // Frame FSM with bit counter and registered status pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= WAIT_IDLE;
         count     <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
      end else begin
         valid     <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            WAIT_IDLE: begin
               if (!frame_low) begin
                  state <= IDLE;
               end
            end
            IDLE: begin
               if (frame_low) begin
                  count <= CNT_W'(1);
                  busy  <= 1'b1;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               if (frame_low) begin
                  if (count == LAST_CNT) begin
                     valid <= 1'b1;
                     count <= '0;
                     busy  <= 1'b0;
                     state <= DRAIN;
                  end else begin
                     count <= count + CNT_W'(1);
                  end
               end else begin
                  // Sync went idle before the last bit: short frame.
                  frame_err <= 1'b1;
                  count     <= '0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            DRAIN: begin
               if (frame_low) begin
                  // Sync still active past the last bit: over-length frame.
                  frame_err <= 1'b1;
                  state     <= WAIT_IDLE;
               end else begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= WAIT_IDLE;
            end
         endcase
      end
   end

   dac_rx_lane #(.WIDTH(WIDTH)) u_lane_a (
      .clk   (clk),
      .rst   (rst),
      .din   (dina_s),
      .start (lane_start),
      .shift (lane_shift),
      .load  (lane_load),
      .word  (out_a)
   );

   dac_rx_lane #(.WIDTH(WIDTH)) u_lane_b (
      .clk   (clk),
      .rst   (rst),
      .din   (dinb_s),
      .start (lane_start),
      .shift (lane_shift),
      .load  (lane_load),
      .word  (out_b)
   );

endmodule

// File: tb/tb_dac_frame_rx.sv
// Self-checking bench for dac_frame_rx: table of frames driven serially,
// expected pulses queued with their due cycle and matched by a monitor.
module tb_dac_frame_rx;

   localparam int W = 16;
`ifdef DAC_FRAME_RX_IN_REG_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 0;
`endif

   typedef struct {
      int          len;       // cycles with sync low
      int          gap;       // idle cycles after the frame
      logic [15:0] a;
      logic [15:0] b;
      bit          exp_valid;
      bit          exp_err;
      logic [15:0] exp_a;
      logic [15:0] exp_b;
   } frame_vec_t;

   typedef struct {
      bit          is_err;
      logic [15:0] a;
      logic [15:0] b;
      int          at;
   } sb_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          sync = 1'b1;
   logic          dina = 1'b0;
   logic          dinb = 1'b0;
   logic [W-1:0]  out_a;
   logic [W-1:0]  out_b;
   logic          valid;
   logic          frame_err;
   logic          busy;

   int            n_checks = 0;
   int            n_errors = 0;
   int            cyc = 0;
   int            busy_cnt = 0;
   int            valid_seen = 0;
   int            err_seen = 0;
   logic [15:0]   last_a = '0;
   logic [15:0]   last_b = '0;
   sb_t           sb[$];

   dac_frame_rx #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .sync      (sync),
      .dina      (dina),
      .dinb      (dinb),
      .out_a     (out_a),
      .out_b     (out_b),
      .valid     (valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: samples outputs 1 time unit after each rising edge.
   initial begin
      sb_t e;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (rst === 1'b1) begin
            last_a = '0;
            last_b = '0;
         end
         if (busy === 1'b1) busy_cnt++;
         while (sb.size() > 0 && sb[0].at < cyc) begin
            e = sb.pop_front();
            check(e.is_err ? "missing_frame_err" : "missing_valid", cyc, e.at);
         end
         if (valid === 1'b1 || frame_err === 1'b1) begin
            if (valid === 1'b1) valid_seen++;
            if (frame_err === 1'b1) err_seen++;
            check("valid_err_exclusive", {31'd0, valid & frame_err}, 32'd0);
            if (sb.size() == 0 || sb[0].at != cyc) begin
               check("unexpected_pulse", {30'd0, valid, frame_err}, 32'd0);
            end else begin
               e = sb.pop_front();
               check("pulse_kind_err", {31'd0, frame_err}, {31'd0, e.is_err});
               if (!e.is_err) begin
                  check("out_a", {16'd0, out_a}, {16'd0, e.a});
                  check("out_b", {16'd0, out_b}, {16'd0, e.b});
                  last_a = e.a;
                  last_b = e.b;
               end else begin
                  check("out_a_held", {16'd0, out_a}, {16'd0, last_a});
                  check("out_b_held", {16'd0, out_b}, {16'd0, last_b});
               end
            end
         end
      end
   end

   task automatic push(input bit is_err, input logic [15:0] a, input logic [15:0] b);
      sb_t e;
      e.is_err = is_err;
      e.a      = a;
      e.b      = b;
      e.at     = cyc + 1 + LAT;
      sb.push_back(e);
   endtask

   // Drive one frame (len low cycles) followed by gap idle cycles.
   task automatic send_frame(input frame_vec_t v);
      for (int i = 1; i <= v.len; i++) begin
         @(negedge clk);
         sync = 1'b0;
         dina = (i <= 16) ? v.a[16-i] : 1'b0;
         dinb = (i <= 16) ? v.b[16-i] : 1'b0;
         if (i == 16 && v.exp_valid) push(1'b0, v.exp_a, v.exp_b);
         if (i == 17 && v.exp_err)   push(1'b1, '0, '0);
      end
      for (int g = 0; g < v.gap; g++) begin
         @(negedge clk);
         sync = 1'b1;
         dina = 1'b0;
         dinb = 1'b0;
         if (g == 0 && v.len < 16 && v.exp_err) push(1'b1, '0, '0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      frame_vec_t vecs[9];
      frame_vec_t fv;
      // len gap a b exp_valid exp_err exp_a exp_b
      vecs[0] = '{16, 4, 16'hA5C3, 16'h0F0F, 1'b1, 1'b0, 16'hA5C3, 16'h0F0F};
      vecs[1] = '{16, 1, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 16'h0001};
      vecs[2] = '{16, 3, 16'h8000, 16'h7FFE, 1'b1, 1'b0, 16'h8000, 16'h7FFE};
      vecs[3] = '{10, 3, 16'h1111, 16'h2222, 1'b0, 1'b1, 16'h0000, 16'h0000};
      vecs[4] = '{20, 2, 16'h1234, 16'h5678, 1'b1, 1'b1, 16'h1234, 16'h5678};
      vecs[5] = '{16, 1, 16'h3C3C, 16'hC3C3, 1'b1, 1'b0, 16'h3C3C, 16'hC3C3};
      vecs[6] = '{1,  2, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'h0000, 16'h0000};
      vecs[7] = '{15, 2, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'h0000, 16'h0000};
      vecs[8] = '{16, 2, 16'h0000, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 16'hFFFF};

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_out_a", {16'd0, out_a}, 32'd0);
      check("rst_out_b", {16'd0, out_b}, 32'd0);
      check("rst_valid", {31'd0, valid}, 32'd0);
      check("rst_frame_err", {31'd0, frame_err}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // First frame: also measure busy duration.
      busy_cnt = 0;
      send_frame(vecs[0]);
      check("busy_cycles", busy_cnt, 32'd15);

      for (int k = 1; k < 9; k++) begin
         send_frame(vecs[k]);
      end

      // Reset asserted at bit 7 of a frame; the remainder of that frame is ignored.
      for (int i = 1; i <= 7; i++) begin
         @(negedge clk);
         sync = 1'b0;
         dina = 1'b1;
         dinb = 1'b1;
      end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_out_a", {16'd0, out_a}, 32'd0);
      check("midrst_out_b", {16'd0, out_b}, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      sync = 1'b1;
      dina = 1'b0;
      dinb = 1'b0;
      repeat (2) @(negedge clk);
      fv = '{16, 4, 16'hDEAD, 16'hBEEF, 1'b1, 1'b0, 16'hDEAD, 16'hBEEF};
      send_frame(fv);

      repeat (6) @(negedge clk);
      check("scoreboard_empty", sb.size(), 32'd0);
      check("valid_pulses", valid_seen, 32'd7);
      check("frame_err_pulses", err_seen, 32'd4);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
